// File: rtl/audio_agc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : audio_agc_pkg                                                    |
// | Brief   : Shared constants for the audio AGC capture path.                 |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package audio_agc_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_THRESH = 2'd2;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_CAPTURE   = 3;
    localparam int STAT_COUNT_LSB = 16;

    localparam int RDCTRL_EN    = 0;
    localparam int RDCTRL_FLUSH = 1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo_core                                                   |
// | Brief   : Single-clock FIFO with async-read head, count and sticky overflow.|
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sync_fifo_core #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overflow
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_do_pop  = i_pop & ~w_empty & ~i_clear;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_clear;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/audio_sample_rdfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : audio_sample_rdfifo                                              |
// | Brief   : rdctrl-gated audio sample FIFO drained over an Avalon-MM slave.  |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module audio_sample_rdfifo
    import audio_agc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int THRESH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          rdctrl,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read_n,
    output logic [31:0]         readdata,
    output logic                irq
);

    localparam logic [AW:0] c_thresh = (AW+1)'(THRESH);

    logic                r_flush_q;
    logic                r_irq;
    logic                w_flush_evt;
    logic                w_push;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_head;
    logic [AW:0]         w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_overflow;
    logic [31:0]         w_status;

    assign w_flush_evt = rdctrl[RDCTRL_FLUSH] & ~r_flush_q;
    assign w_push      = sample_valid & rdctrl[RDCTRL_EN];
    assign w_pop       = chipselect & ~read_n & (address == ADDR_DATA);

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (SAMPLE_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_wdata    (sample_data),
        .i_pop      (w_pop),
        .i_clear    (w_flush_evt),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_q <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_flush_q <= rdctrl[RDCTRL_FLUSH];
            r_irq     <= (w_count >= c_thresh);
        end
    end

    always_comb begin
        w_status                               = '0;
        w_status[STAT_EMPTY]                   = w_empty;
        w_status[STAT_FULL]                    = w_full;
        w_status[STAT_OVERFLOW]                = w_overflow;
        w_status[STAT_CAPTURE]                 = rdctrl[RDCTRL_EN];
        w_status[STAT_COUNT_LSB +: AW+1]       = w_count;
    end

    // Zero-wait read: the head is presented in the same cycle the pop is issued.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!w_empty) begin
                    readdata = {{(32-SAMPLE_W){w_head[SAMPLE_W-1]}}, w_head};
                end
            end
            ADDR_STATUS: readdata = w_status;
            ADDR_THRESH: readdata = 32'(THRESH);
            default:     readdata = '0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_rdfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_audio_sample_rdfifo                                           |
// | Brief   : Self-checking bench with a queue-based reference model.          |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_audio_sample_rdfifo;

    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int THRESH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rdctrl;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq [$];
    logic        m_ovf;
    logic        m_irq;
    logic        m_fq;
    logic [15:0] vals [DEPTH+1];

    audio_sample_rdfifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rdctrl       (rdctrl),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .address      (address),
        .chipselect   (chipselect),
        .read_n       (read_n),
        .readdata     (readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 2'd0) begin
            if (mq.size() != 0) r = sext(mq[0]);
        end else if (a == 2'd1) begin
            r = (32'(mq.size()) << 16) | (32'(rdctrl[0]) << 3) | (32'(m_ovf) << 2)
              | (32'(mq.size() == DEPTH) << 1) | 32'(mq.size() == 0);
        end else if (a == 2'd2) begin
            r = 32'(THRESH);
        end
        return r;
    endfunction

    // Advance one clock and apply the same inputs to the reference model.
    task automatic cycle();
        logic flush, pop, push;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_irq = 1'b0;
            m_fq  = 1'b0;
        end else begin
            m_irq = (mq.size() >= THRESH);
            flush = rdctrl[1] & ~m_fq;
            pop   = chipselect & ~read_n & (address == 2'd0) & (mq.size() != 0);
            push  = sample_valid & rdctrl[0];
            if (flush) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (mq.size() < DEPTH) mq.push_back(sample_data);
                    else m_ovf = 1'b1;
                end
            end
            m_fq = rdctrl[1];
        end
        #1;
    endtask

    task automatic idle(input logic [1:0] rc);
        rdctrl = rc; sample_valid = 1'b0; sample_data = 16'h0;
        chipselect = 1'b0; read_n = 1'b1; address = 2'd1;
    endtask

    task automatic do_flush();
        idle(2'b11); cycle();
        idle(2'b01); cycle();
    endtask

    task automatic push_one(input logic [15:0] v);
        sample_valid = 1'b1; sample_data = v; cycle();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdctrl = 2'($urandom); sample_valid = 1'($urandom); sample_data = 16'($urandom);
            chipselect = 1'($urandom); read_n = 1'($urandom); address = 2'($urandom);
            cycle();
        end
        idle(2'b00); cycle();
        reset = 1'b0;
        #1;
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", readdata, 32'h1); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        address = 2'd0; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", readdata); end
        address = 2'd2; #1;
        checks++; if (readdata !== 32'(THRESH)) begin errors++; $display("FAIL thresh_reg got %h exp %h", readdata, THRESH); end
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp[0] = 32'h00007FFF; exp[1] = 32'hFFFF8000; exp[2] = 32'h00000001;
        idle(2'b01);
        push_one(16'h7FFF); push_one(16'h8000); push_one(16'h0001);
        address = 2'd1; #1;
        checks++; if (readdata !== 32'h00030008) begin errors++; $display("FAIL basic_status got %h exp %h", readdata, 32'h00030008); end
        for (int i = 0; i < 3; i++) begin
            chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
            checks++; if (readdata !== exp[i]) begin errors++; $display("FAIL basic_pop%0d got %h exp %h", i, readdata, exp[i]); end
            cycle();
        end
        idle(2'b01); #1;
        checks++; if (readdata !== 32'h00000009) begin errors++; $display("FAIL basic_empty got %h exp %h", readdata, 32'h9); end
    endtask

    task automatic test_overflow();
        do_flush();
        for (int i = 0; i <= DEPTH; i++) begin
            vals[i] = 16'($urandom);
            push_one(vals[i]);
        end
        address = 2'd1; #1;
        checks++; if (readdata !== 32'h0040000E) begin errors++; $display("FAIL ovf_status got %h exp %h", readdata, 32'h0040000E); end
        for (int i = 0; i < DEPTH; i++) begin
            chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
            checks++; if (readdata !== sext(vals[i])) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, readdata, sext(vals[i])); end
            cycle();
        end
        idle(2'b01); #1;
        checks++; if (readdata !== 32'h0000000D) begin errors++; $display("FAIL ovf_sticky got %h exp %h", readdata, 32'hD); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] nv;
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 16'($urandom);
            push_one(vals[i]);
        end
        nv = 16'($urandom);
        sample_valid = 1'b1; sample_data = nv;
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
        checks++; if (readdata !== sext(vals[0])) begin errors++; $display("FAIL fpp_head got %h exp %h", readdata, sext(vals[0])); end
        cycle();
        idle(2'b01); #1;
        checks++; if (readdata !== 32'h0040000A) begin errors++; $display("FAIL fpp_status got %h exp %h", readdata, 32'h0040000A); end
        for (int i = 0; i < DEPTH; i++) begin
            chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
            checks++; if (readdata !== exp_read(2'd0)) begin errors++; $display("FAIL fpp_pop%0d got %h exp %h", i, readdata, exp_read(2'd0)); end
            cycle();
        end
        checks++; if (vals[0] === nv && 1'b0) begin errors++; end
        address = 2'd1; chipselect = 1'b0; #1;
        checks++; if (readdata !== 32'h00000009) begin errors++; $display("FAIL fpp_drained got %h exp %h", readdata, 32'h9); end
    endtask

    task automatic test_flush();
        idle(2'b01);
        for (int i = 0; i < 5; i++) push_one(16'($urandom));
        rdctrl = 2'b11; sample_valid = 1'b1; sample_data = 16'h1234;
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        cycle();
        idle(2'b11); #1;
        checks++; if (readdata !== 32'h00000009) begin errors++; $display("FAIL flush_status got %h exp %h", readdata, 32'h9); end
        for (int i = 0; i < 10; i++) cycle();
        rdctrl = 2'b01;
        push_one(16'h5A5A);
        address = 2'd1; #1;
        checks++; if (readdata !== 32'h00010008) begin errors++; $display("FAIL flush_hold got %h exp %h", readdata, 32'h00010008); end
    endtask

    task automatic test_irq();
        idle(2'b00);
        for (int i = 0; i < 4; i++) push_one(16'($urandom));
        #1;
        checks++; if (readdata !== 32'h00010000) begin errors++; $display("FAIL cap_off got %h exp %h", readdata, 32'h00010000); end
        rdctrl = 2'b01;
        for (int i = 1; i < THRESH; i++) begin
            push_one(16'($urandom));
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fill%0d got %b exp 0", i, irq); end
        end
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0; cycle();
        idle(2'b01);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag got %b exp 1", irq); end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rdctrl[0]    = ($urandom_range(0, 4) != 0);
            rdctrl[1]    = ($urandom_range(0, 40) == 0);
            sample_valid = 1'($urandom);
            sample_data  = 16'($urandom);
            chipselect   = 1'($urandom);
            read_n       = ($urandom_range(0, 2) == 0);
            address      = 2'($urandom);
            #1;
            checks++; if (readdata !== exp_read(address)) begin errors++; $display("FAIL rand_read%0d a=%0d got %h exp %h", i, address, readdata, exp_read(address)); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq%0d got %b exp %b", i, irq, m_irq); end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_flush();
        for (int i = 0; i < 40; i++) push_one(16'($urandom));
        reset = 1'b1; rdctrl = 2'b11; sample_valid = 1'b1;
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        cycle();
        reset = 1'b0; idle(2'b00); #1;
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL midreset_status got %h exp %h", readdata, 32'h1); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", irq); end
    endtask

    initial begin
        m_ovf = 1'b0; m_irq = 1'b0; m_fq = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_irq();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
